memory_dp_init: RTL and testbench

- Parametrised dual-port synchronous RAM; successor to the basic dual-port external-view memory.
- Adds configurable read latency, deterministic cross-port collision and read-during-write rules, out-of-range protection, and a hardware init engine that fills every location after reset or on request.
- Used as the storage primitive behind generated memory blocks. Exports the raw array for debug and testbench backdoor access.

---
 rtl/memory_dp_pkg.sv | 17 +
 rtl/memory_if.sv | 33 +++
 rtl/memory_rd_pipe.sv | 38 +++
 rtl/memory_dp_init.sv | 183 ++++++++++++++++++
 tb/tb_memory_dp_init.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/memory_dp_pkg.sv
// Shared definitions for the dual-port memory with init engine.
//   state_t        : init engine state (INIT fills the array, READY serves accesses)
//   RD_LATENCY_MAX : largest supported read latency
//   RDW_OLD/RDW_NEW: cross-port read-during-write behaviour selectors
package memory_dp_pkg;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_t;

    localparam int RD_LATENCY_MAX = 4;

    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

endpackage

// File: rtl/memory_if.sv
// Single memory access port.
//   enable     : access request this cycle
//   wr_en      : 1 = write, 0 = read (qualified by enable)
//   addr       : word address (full interface width, range-checked by the memory)
//   write_data : data to write
//   read_data  : data returned by the memory
// dst is the memory side, src the requester side.
interface memory_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              enable;
    logic              wr_en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] read_data;

    modport dst (
        input  enable,
        input  wr_en,
        input  addr,
        input  write_data,
        output read_data
    );

    modport src (
        output enable,
        output wr_en,
        output addr,
        output write_data,
        input  read_data
    );
endinterface

// File: rtl/memory_rd_pipe.sv
// Read-data pipeline for one memory port.
//   clk, rst_n : clock, asynchronous active-low reset (all stages clear to 0)
//   load       : a read was accepted this cycle; stage 0 captures din
//   din        : word read from the array (or 0 for an out-of-range read)
//   dout       : word presented on read_data, RD_LATENCY cycles after the load
// Stage 0 holds its value between reads; later stages shift every cycle, so
// once a read reaches the output the whole chain holds that word.
module memory_rd_pipe #(
    parameter int RD_LATENCY = 1,
    parameter int WIDTH      = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_reg [RD_LATENCY];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                stage_reg[i] <= '0;
            end
        end else begin
            if (load) begin
                stage_reg[0] <= din;
            end
            for (int i = 1; i < RD_LATENCY; i++) begin
                stage_reg[i] <= stage_reg[i-1];
            end
        end
    end

    assign dout = stage_reg[RD_LATENCY-1];

endmodule

// File: rtl/memory_dp_init.sv
// Dual-port synchronous RAM with configurable read latency, deterministic
// collision / read-during-write rules, out-of-range protection and an init
// engine that fills every word with INIT_VALUE.
//   clk, rst_n  : clock, asynchronous active-low reset
//   mem_portA/B : access ports (enable, wr_en, addr, write_data, read_data)
//   mem         : read-only view of the storage array (debug / backdoor)
//   init_start  : pulse in READY to refill the array with INIT_VALUE
//   init_done   : high while the memory accepts accesses
//   collision   : one-cycle pulse after both ports wrote the same word
//   drop_err    : sticky flag, set when any access is dropped; reset clears it
module memory_dp_init
    import memory_dp_pkg::*;
#(
    parameter int    DEPTH      = 2,
    parameter type   data_t     = logic [1:0],
    parameter int    RD_LATENCY = 1,
    parameter bit    INIT_EN    = 1'b1,
    parameter data_t INIT_VALUE = '0,
    parameter int    RDW_MODE   = 0
) (
    input  logic  clk,
    input  logic  rst_n,
    memory_if.dst mem_portA,
    memory_if.dst mem_portB,
    output data_t mem [DEPTH],
    input  logic  init_start,
    output logic  init_done,
    output logic  collision,
    output logic  drop_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int DW = $bits(data_t);

    if (RD_LATENCY < 1 || RD_LATENCY > RD_LATENCY_MAX) begin : g_bad_latency
        $error("memory_dp_init: RD_LATENCY %0d outside 1..%0d", RD_LATENCY, RD_LATENCY_MAX);
    end
    if (RDW_MODE != RDW_OLD && RDW_MODE != RDW_NEW) begin : g_bad_rdw
        $error("memory_dp_init: RDW_MODE %0d is not RDW_OLD or RDW_NEW", RDW_MODE);
    end
    if (DEPTH < 2) begin : g_bad_depth
        $error("memory_dp_init: DEPTH %0d must be at least 2", DEPTH);
    end

    state_t        state_reg, state_next;
    logic [AW-1:0] cnt_reg, cnt_next;
    logic          collision_reg;
    logic          drop_err_reg;
    data_t         mem_reg [DEPTH];
    logic          ready;

    // Port fields gathered into two-entry arrays so both ports share one
    // generate body. Index 0 is port A, index 1 is port B.
    logic          port_en    [2];
    logic          port_we    [2];
    logic [31:0]   port_addr  [2];
    data_t         port_wdata [2];
    logic [DW-1:0] port_rdata [2];

    logic          in_range   [2];
    logic [AW-1:0] idx        [2];
    logic          wr_ok      [2];
    logic          rd_go      [2];
    logic          drop       [2];
    logic          dual_write;

    assign port_en[0]    = mem_portA.enable;
    assign port_we[0]    = mem_portA.wr_en;
    assign port_addr[0]  = 32'(mem_portA.addr);
    assign port_wdata[0] = data_t'(mem_portA.write_data);
    assign mem_portA.read_data = data_t'(port_rdata[0]);

    assign port_en[1]    = mem_portB.enable;
    assign port_we[1]    = mem_portB.wr_en;
    assign port_addr[1]  = 32'(mem_portB.addr);
    assign port_wdata[1] = data_t'(mem_portB.write_data);
    assign mem_portB.read_data = data_t'(port_rdata[1]);

    assign ready = (state_reg == READY);

    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        localparam int OTHER = 1 - gi;
        data_t rd_word;

        // Range check on the full interface width; the narrowed index is
        // only trusted when in_range is set.
        assign in_range[gi] = (port_addr[gi] < 32'(DEPTH));
        assign idx[gi]      = AW'(port_addr[gi]);
        assign wr_ok[gi]    = ready && port_en[gi] && port_we[gi] && in_range[gi];
        assign rd_go[gi]    = ready && port_en[gi] && !port_we[gi];
        assign drop[gi]     = port_en[gi] && (!ready || !in_range[gi]);

        // Out-of-range reads still load the pipeline, with zero. In
        // write-through mode a same-cycle write from the other port is
        // forwarded instead of the stored word.
        always_comb begin
            rd_word = '0;
            if (in_range[gi]) begin
                rd_word = mem_reg[idx[gi]];
                if (RDW_MODE == RDW_NEW && wr_ok[OTHER] && idx[OTHER] == idx[gi]) begin
                    rd_word = port_wdata[OTHER];
                end
            end
        end

        memory_rd_pipe #(
            .RD_LATENCY (RD_LATENCY),
            .WIDTH      (DW)
        ) u_rd_pipe (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (rd_go[gi]),
            .din   (rd_word),
            .dout  (port_rdata[gi])
        );
    end

    assign dual_write = wr_ok[0] && wr_ok[1] && (idx[0] == idx[1]);

    // Init engine: one word per cycle, leaves INIT on the cycle that writes
    // the last word so init_done rises exactly DEPTH cycles after entry.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            INIT: begin
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == AW'(DEPTH - 1)) begin
                    state_next = READY;
                    cnt_next   = '0;
                end
            end
            READY: begin
                if (init_start) begin
                    state_next = INIT;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = READY;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= INIT_EN ? INIT : READY;
            cnt_reg       <= '0;
            collision_reg <= 1'b0;
            drop_err_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            collision_reg <= dual_write;
            drop_err_reg  <= drop_err_reg | drop[0] | drop[1];
        end
    end

    // Storage is never reset. Port B is written first so that port A wins
    // a same-address double write.
    always_ff @(posedge clk) begin
        if (state_reg == INIT) begin
            mem_reg[cnt_reg] <= INIT_VALUE;
        end else begin
            if (wr_ok[1]) begin
                mem_reg[idx[1]] <= port_wdata[1];
            end
            if (wr_ok[0]) begin
                mem_reg[idx[0]] <= port_wdata[0];
            end
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem_view
        assign mem[gi] = mem_reg[gi];
    end

    assign init_done = ready;
    assign collision = collision_reg;
    assign drop_err  = drop_err_reg;

endmodule

// File: tb/tb_memory_dp_init.sv
// Bench for memory_dp_init: two instances (old-data and write-through
// read-during-write) share the same stimulus. Port A reads are tracked by a
// scoreboard that releases each expected word RD_LATENCY cycles after the
// sampling edge.
module tb_memory_dp_init;

    localparam int DEPTH  = 6;
    localparam int RD_LAT = 3;
    localparam logic [7:0] IV = 8'hA5;

    logic clk = 1'b0;
    logic rst_n;
    logic init_start;
    logic       a_en, a_we, b_en, b_we;
    logic [3:0] a_addr, b_addr;
    logic [7:0] a_wd, b_wd;
    logic       a_track = 1'b0;

    logic [7:0] mem0 [DEPTH];
    logic [7:0] mem1 [DEPTH];
    logic init_done0, coll0, drop0;
    logic init_done1, coll1, drop1;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int due_q [$];
    logic [7:0] exp0_q [$];
    logic [7:0] exp1_q [$];
    logic [7:0] last0 = 8'h00;
    logic [7:0] last1 = 8'h00;

    always #5 clk = ~clk;

    memory_if #(.ADDR_W(4), .DATA_W(8)) if_a0 ();
    memory_if #(.ADDR_W(4), .DATA_W(8)) if_b0 ();
    memory_if #(.ADDR_W(4), .DATA_W(8)) if_a1 ();
    memory_if #(.ADDR_W(4), .DATA_W(8)) if_b1 ();

    assign if_a0.enable = a_en;  assign if_a0.wr_en = a_we;
    assign if_a0.addr   = a_addr; assign if_a0.write_data = a_wd;
    assign if_b0.enable = b_en;  assign if_b0.wr_en = b_we;
    assign if_b0.addr   = b_addr; assign if_b0.write_data = b_wd;
    assign if_a1.enable = a_en;  assign if_a1.wr_en = a_we;
    assign if_a1.addr   = a_addr; assign if_a1.write_data = a_wd;
    assign if_b1.enable = b_en;  assign if_b1.wr_en = b_we;
    assign if_b1.addr   = b_addr; assign if_b1.write_data = b_wd;

    memory_dp_init #(
        .DEPTH(DEPTH), .data_t(logic [7:0]), .RD_LATENCY(RD_LAT),
        .INIT_EN(1'b1), .INIT_VALUE(IV), .RDW_MODE(0)
    ) u_dut_old (
        .clk(clk), .rst_n(rst_n), .mem_portA(if_a0), .mem_portB(if_b0),
        .mem(mem0), .init_start(init_start), .init_done(init_done0),
        .collision(coll0), .drop_err(drop0)
    );

    memory_dp_init #(
        .DEPTH(DEPTH), .data_t(logic [7:0]), .RD_LATENCY(RD_LAT),
        .INIT_EN(1'b1), .INIT_VALUE(IV), .RDW_MODE(1)
    ) u_dut_new (
        .clk(clk), .rst_n(rst_n), .mem_portA(if_a1), .mem_portB(if_b1),
        .mem(mem1), .init_start(init_start), .init_done(init_done1),
        .collision(coll1), .drop_err(drop1)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        a_en = 1'b0; a_we = 1'b0; a_addr = '0; a_wd = '0;
        b_en = 1'b0; b_we = 1'b0; b_addr = '0; b_wd = '0;
    endtask

    // Advance one clock; inputs change and outputs are sampled on the negedge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Scoreboard producer: record the edge at which each tracked read lands.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (a_track) due_q.push_back(cyc + RD_LAT - 1);
    end

    // Scoreboard consumer: one cycle before landing the output must still
    // show the previous word; on the landing cycle it must show the new one.
    always @(negedge clk) begin
        if (due_q.size() > 0) begin
            if (due_q[0] == cyc) begin
                logic [7:0] e0, e1;
                e0 = exp0_q.pop_front();
                e1 = exp1_q.pop_front();
                void'(due_q.pop_front());
                check_eq("rdA_rdw_old", if_a0.read_data, e0);
                check_eq("rdA_rdw_new", if_a1.read_data, e1);
                $display("read landed cyc=%0d old=0x%0h new=0x%0h", cyc, if_a0.read_data, if_a1.read_data);
                last0 = e0;
                last1 = e1;
            end else if (due_q[0] == cyc + 1) begin
                check_eq("rdA_early_old", if_a0.read_data, last0);
                check_eq("rdA_early_new", if_a1.read_data, last1);
            end
        end
    end

    task automatic do_read(input logic [3:0] addr, input logic [7:0] exp0, input logic [7:0] exp1);
        a_en = 1'b1; a_we = 1'b0; a_addr = addr; a_track = 1'b1;
        exp0_q.push_back(exp0);
        exp1_q.push_back(exp1);
        tick();
        idle();
        a_track = 1'b0;
        for (int k = 0; k < 8 && exp0_q.size() > 0; k++) tick();
        if (exp0_q.size() > 0) begin
            check_eq("rd_timeout", exp0_q.size(), 0);
            exp0_q.delete(); exp1_q.delete(); due_q.delete();
        end
    endtask

    task automatic wait_init(input string tag);
        for (int k = 1; k <= DEPTH; k++) begin
            tick();
            check_eq({tag, "_done"}, init_done0, (k == DEPTH) ? 1 : 0);
        end
        $display("%s: init_done=%0b after %0d cycles", tag, init_done0, DEPTH);
    endtask

    // Assert reset between clock edges and check the outputs clear at once.
    task automatic async_reset(input string tag);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq({tag, "_init_done"}, init_done0, 0);
        check_eq({tag, "_drop_err"}, drop0, 0);
        check_eq({tag, "_collision"}, coll0, 0);
        check_eq({tag, "_rd_old"}, if_a0.read_data, 0);
        check_eq({tag, "_rd_new"}, if_a1.read_data, 0);
        $display("%s: async reset applied", tag);
        last0 = 8'h00;
        last1 = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        init_start = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("rst_init_done", init_done0, 0);
        check_eq("rst_drop_err", drop0, 0);
        check_eq("rst_collision", coll0, 0);
        check_eq("rst_rdA", if_a0.read_data, 0);
        check_eq("rst_rdB", if_b0.read_data, 0);
        rst_n = 1'b1;

        // Power-up fill
        wait_init("init1");
        for (int i = 0; i < DEPTH; i++) check_eq($sformatf("init_mem%0d", i), mem0[i], IV);
        check_eq("init_drop_err", drop0, 0);

        // Write then read back with latency
        a_en = 1'b1; a_we = 1'b1; a_addr = 4'd2; a_wd = 8'h3C;
        tick();
        idle();
        check_eq("wr_no_collision", coll0, 0);
        do_read(4'd2, 8'h3C, 8'h3C);
        repeat (3) tick();
        check_eq("rd_hold", if_a0.read_data, 8'h3C);

        // Same-address double write
        a_en = 1'b1; a_we = 1'b1; a_addr = 4'd4; a_wd = 8'h11;
        b_en = 1'b1; b_we = 1'b1; b_addr = 4'd4; b_wd = 8'h22;
        tick();
        idle();
        check_eq("coll_mem_old", mem0[4], 8'h11);
        check_eq("coll_mem_new", mem1[4], 8'h11);
        check_eq("coll_pulse", coll0, 1);
        $display("collision write: mem[4]=0x%0h collision=%0b", mem0[4], coll0);
        tick();
        check_eq("coll_clear", coll0, 0);

        // Cross-port read during write
        b_en = 1'b1; b_we = 1'b1; b_addr = 4'd1; b_wd = 8'h77;
        do_read(4'd1, IV, 8'h77);
        check_eq("rdw_mem", mem0[1], 8'h77);
        check_eq("rdw_rdB_unchanged", if_b0.read_data, 0);

        // Re-initialisation request; write attempted while filling
        init_start = 1'b1;
        tick();
        init_start = 1'b0;
        check_eq("restart_busy", init_done0, 0);
        a_en = 1'b1; a_we = 1'b1; a_addr = 4'd5; a_wd = 8'h99;
        tick();
        idle();
        check_eq("drop_set", drop0, 1);
        check_eq("drop_nowrite", mem0[5], IV);
        for (int k = 3; k <= DEPTH + 1; k++) begin
            tick();
            check_eq("reinit_done", init_done0, (k == DEPTH + 1) ? 1 : 0);
        end
        check_eq("reinit_mem1", mem0[1], IV);
        check_eq("reinit_mem4", mem0[4], IV);
        check_eq("reinit_mem5", mem0[5], IV);
        check_eq("drop_sticky", drop0, 1);

        // Out-of-range read, then reset in the middle of an init
        async_reset("rst2");
        wait_init("init2");
        check_eq("drop_clear", drop0, 0);
        do_read(4'd2, IV, IV);
        check_eq("inrange_no_drop", drop0, 0);
        do_read(4'd7, 8'h00, 8'h00);
        check_eq("oor_drop", drop0, 1);
        do_read(4'd2, IV, IV);
        init_start = 1'b1;
        tick();
        init_start = 1'b0;
        tick();
        async_reset("rst3");
        wait_init("init3");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
